// File: rtl/isle_tmds_pkg.sv
// Shared constants for the TMDS channel encoder: symbol width, control-period
// codes and a byte popcount helper.
package isle_tmds_pkg;

  localparam int SYM_W = 10;

  localparam logic [SYM_W-1:0] CTRL_SYM_00 = 10'h354;
  localparam logic [SYM_W-1:0] CTRL_SYM_01 = 10'h0AB;
  localparam logic [SYM_W-1:0] CTRL_SYM_10 = 10'h154;
  localparam logic [SYM_W-1:0] CTRL_SYM_11 = 10'h2AB;

  function automatic logic [3:0] ones8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/tmds_qm_stage.sv
// Transition-minimising stage: chains din through XOR or XNOR and tags the
// chosen operation in q_m[8] (1 = XOR, 0 = XNOR). Purely combinational.
module tmds_qm_stage
  import isle_tmds_pkg::*;
(
  input  logic [7:0] din_i,
  output logic [8:0] qm_o
);

  logic [3:0] n1d_c;
  logic       use_xnor_c;
  logic [7:0] chain_c;

  assign n1d_c      = ones8(din_i);
  assign use_xnor_c = (n1d_c > 4'd4) || ((n1d_c == 4'd4) && !din_i[0]);

  // Local accumulator keeps the bit chain free of a self-referencing net.
  always_comb begin
    logic [7:0] acc;
    acc    = '0;
    acc[0] = din_i[0];
    for (int i = 1; i < 8; i++) begin
      acc[i] = use_xnor_c ? ~(acc[i-1] ^ din_i[i]) : (acc[i-1] ^ din_i[i]);
    end
    chain_c = acc;
  end

  assign qm_o = {~use_xnor_c, chain_c};

endmodule

// File: rtl/tmds_encoder.sv
// TMDS 8b/10b channel encoder with running-disparity control.
// Define TMDS_PIPE_EN to register q_m, its disparity, de and ctrl (2-cycle latency).
module tmds_encoder
  import isle_tmds_pkg::*;
#(
  parameter int CNTW = 5
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic             de,
  input  logic [7:0]       din,
  input  logic [1:0]       ctrl,
  output logic [SYM_W-1:0] tmds
);

  localparam logic signed [CNTW-1:0] CNT_ZERO = '0;
  localparam logic signed [CNTW-1:0] CNT_TWO  = CNTW'(2);

  logic [8:0]             qm_c;
  logic [CNTW-1:0]        n1x2_c;
  logic signed [CNTW-1:0] diff_c;

  logic [8:0]             qm_s;
  logic signed [CNTW-1:0] diff_s;
  logic                   de_s;
  logic [1:0]             ctrl_s;

  logic [SYM_W-1:0]       tmds_q, tmds_d;
  logic signed [CNTW-1:0] cnt_q, cnt_d;

  tmds_qm_stage u_qm (
    .din_i (din),
    .qm_o  (qm_c)
  );

  // N1q - N0q == 2*N1q - 8 over the low eight q_m bits.
  assign n1x2_c = CNTW'({ones8(qm_c[7:0]), 1'b0});
  assign diff_c = $signed(n1x2_c - CNTW'(8));

`ifdef TMDS_PIPE_EN
  logic [8:0]             qm_q;
  logic signed [CNTW-1:0] diff_q;
  logic                   de_q;
  logic [1:0]             ctrl_q;

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      qm_q   <= '0;
      diff_q <= CNT_ZERO;
      de_q   <= 1'b0;
      ctrl_q <= 2'b00;
    end else begin
      qm_q   <= qm_c;
      diff_q <= diff_c;
      de_q   <= de;
      ctrl_q <= ctrl;
    end
  end

  assign qm_s   = qm_q;
  assign diff_s = diff_q;
  assign de_s   = de_q;
  assign ctrl_s = ctrl_q;
`else
  assign qm_s   = qm_c;
  assign diff_s = diff_c;
  assign de_s   = de;
  assign ctrl_s = ctrl;
`endif

  always_comb begin
    tmds_d = CTRL_SYM_00;
    cnt_d  = CNT_ZERO;
    if (!de_s) begin
      unique case (ctrl_s)
        2'b00:   tmds_d = CTRL_SYM_00;
        2'b01:   tmds_d = CTRL_SYM_01;
        2'b10:   tmds_d = CTRL_SYM_10;
        default: tmds_d = CTRL_SYM_11;
      endcase
    end else if ((cnt_q == CNT_ZERO) || (diff_s == CNT_ZERO)) begin
      if (qm_s[8]) begin
        tmds_d = {2'b01, qm_s[7:0]};
        cnt_d  = cnt_q + diff_s;
      end else begin
        tmds_d = {2'b10, ~qm_s[7:0]};
        cnt_d  = cnt_q - diff_s;
      end
    // cnt_q is known non-zero here, so its sign bit alone separates >0 from <0.
    end else if ((!cnt_q[CNTW-1] && (diff_s > CNT_ZERO)) ||
                 ( cnt_q[CNTW-1] && (diff_s < CNT_ZERO))) begin
      tmds_d = {1'b1, qm_s[8], ~qm_s[7:0]};
      cnt_d  = cnt_q + (qm_s[8] ? CNT_TWO : CNT_ZERO) - diff_s;
    end else begin
      tmds_d = {1'b0, qm_s[8], qm_s[7:0]};
      cnt_d  = cnt_q + diff_s - (qm_s[8] ? CNT_ZERO : CNT_TWO);
    end
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      tmds_q <= CTRL_SYM_00;
      cnt_q  <= CNT_ZERO;
    end else begin
      tmds_q <= tmds_d;
      cnt_q  <= cnt_d;
    end
  end

  assign tmds = tmds_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// Directed-vector and random bench for tmds_encoder; follows TMDS_PIPE_EN for latency.
module tb_tmds_encoder;

`ifdef TMDS_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk_pix;
  logic       rst_pix;
  logic       de;
  logic [7:0] din;
  logic [1:0] ctrl;
  logic [9:0] tmds;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [9:0] sym;
    int         cnt;
    string      name;
  } exp_t;

  typedef struct {
    logic       de;
    logic [7:0] din;
    logic [1:0] ctrl;
    logic [9:0] sym;
    int         cnt;
  } vec_t;

  exp_t expq[$];
  vec_t vecs[18];

  tmds_encoder #(.CNTW(5)) dut (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .de      (de),
    .din     (din),
    .ctrl    (ctrl),
    .tmds    (tmds)
  );

  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  task automatic check_sym(input string nm, input logic [9:0] act, input logic [9:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: tmds=%h required %h", nm, act, req);
    end
  endtask

  task automatic check_cnt(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: cnt=%0d required %0d", nm, act, req);
    end
  endtask

  task automatic apply(input logic d_e, input logic [7:0] d, input logic [1:0] c,
                       input logic [9:0] es, input int ec, input string nm);
    exp_t e;
    de   = d_e;
    din  = d;
    ctrl = c;
    e.sym = es;
    e.cnt = ec;
    e.name = nm;
    expq.push_back(e);
    @(posedge clk_pix);
    #1;
    if (expq.size() == LAT) begin
      e = expq.pop_front();
      check_sym(e.name, tmds, e.sym);
      check_cnt({e.name, "_cnt"}, int'(dut.cnt_q), e.cnt);
    end
  endtask

  task automatic drain();
    for (int i = 1; i < LAT; i++) apply(1'b0, 8'h00, 2'b00, 10'h354, 0, "drain");
  endtask

  function automatic void model(input logic d_e, input logic [7:0] d, input logic [1:0] c,
                                inout int cnt, output logic [9:0] sym);
    int n1d, n1q, n0q;
    logic [8:0] qm;
    bit xn;
    sym = 10'h354;
    if (!d_e) begin
      case (c)
        2'b00: sym = 10'h354;
        2'b01: sym = 10'h0AB;
        2'b10: sym = 10'h154;
        default: sym = 10'h2AB;
      endcase
      cnt = 0;
      return;
    end
    n1d = $countones(d);
    xn = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
    qm = '0;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? (qm[i-1] ~^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (cnt == 0 || n1q == n0q) begin
      sym = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cnt += qm[8] ? (n1q - n0q) : (n0q - n1q);
    end else if ((cnt > 0 && n1q > n0q) || (cnt < 0 && n0q > n1q)) begin
      sym = {1'b1, qm[8], ~qm[7:0]};
      cnt += 2 * int'(qm[8]) + n0q - n1q;
    end else begin
      sym = {1'b0, qm[8], qm[7:0]};
      cnt += n1q - n0q - 2 * int'(!qm[8]);
    end
  endfunction

  initial begin
    int m_cnt;
    int a;
    logic [9:0] s;
    logic [7:0] r;

    vecs[0]  = '{1'b0, 8'h00, 2'b01, 10'h0AB, 0};
    vecs[1]  = '{1'b0, 8'h00, 2'b10, 10'h154, 0};
    vecs[2]  = '{1'b0, 8'h00, 2'b11, 10'h2AB, 0};
    vecs[3]  = '{1'b0, 8'h00, 2'b00, 10'h354, 0};
    vecs[4]  = '{1'b1, 8'h00, 2'b00, 10'h100, -8};
    vecs[5]  = '{1'b1, 8'h00, 2'b00, 10'h3FF, 2};
    vecs[6]  = '{1'b1, 8'h00, 2'b00, 10'h100, -6};
    vecs[7]  = '{1'b0, 8'h00, 2'b00, 10'h354, 0};
    vecs[8]  = '{1'b1, 8'hFF, 2'b00, 10'h200, -8};
    vecs[9]  = '{1'b1, 8'hFF, 2'b00, 10'h0FF, -2};
    vecs[10] = '{1'b1, 8'h00, 2'b00, 10'h3FF, 8};
    vecs[11] = '{1'b1, 8'h55, 2'b00, 10'h133, 8};
    vecs[12] = '{1'b1, 8'h10, 2'b00, 10'h1F0, 8};
    vecs[13] = '{1'b1, 8'h01, 2'b00, 10'h300, 2};
    vecs[14] = '{1'b1, 8'h01, 2'b00, 10'h300, -4};
    vecs[15] = '{1'b1, 8'h00, 2'b00, 10'h3FF, 6};
    vecs[16] = '{1'b0, 8'h00, 2'b01, 10'h0AB, 0};
    vecs[17] = '{1'b1, 8'h00, 2'b00, 10'h100, -8};

    rst_pix = 1'b1;
    de = 1'b0;
    din = 8'h00;
    ctrl = 2'b00;
    repeat (3) @(posedge clk_pix);
    #1;
    check_sym("reset_hold", tmds, 10'h354);
    check_cnt("reset_hold_cnt", int'(dut.cnt_q), 0);
    rst_pix = 1'b0;
    apply(1'b0, 8'h00, 2'b00, 10'h354, 0, "post_reset");

    for (int i = 0; i < 18; i++) begin
      apply(vecs[i].de, vecs[i].din, vecs[i].ctrl, vecs[i].sym, vecs[i].cnt,
            $sformatf("vec%0d", i));
    end

    apply(1'b0, 8'h00, 2'b00, 10'h354, 0, "pre_random_idle");
    m_cnt = 0;
    for (int i = 0; i < 10000; i++) begin
      r = 8'($urandom_range(0, 255));
      model(1'b1, r, 2'b00, m_cnt, s);
      apply(1'b1, r, 2'b00, s, m_cnt, $sformatf("rand%0d_din%h", i, r));
      a = int'(dut.cnt_q);
      if (a < 0) a = -a;
      checks++;
      if (a > 10) begin
        errors++;
        $display("FAIL cnt_range: |cnt|=%0d required <=10", a);
      end
    end
    apply(1'b0, 8'h00, 2'b00, 10'h354, 0, "random_to_idle");
    drain();

    apply(1'b1, 8'h00, 2'b00, 10'h100, -8, "pre_rst0");
    apply(1'b1, 8'h00, 2'b00, 10'h3FF, 2, "pre_rst1");
    #2;
    rst_pix = 1'b1;
    #1;
    check_sym("async_rst", tmds, 10'h354);
    check_cnt("async_rst_cnt", int'(dut.cnt_q), 0);
    @(posedge clk_pix);
    #1;
    rst_pix = 1'b0;
    expq.delete();
    apply(1'b1, 8'h00, 2'b00, 10'h100, -8, "post_rst_data0");
    apply(1'b1, 8'hFF, 2'b00, 10'h0FF, -2, "post_rst_data1");
    apply(1'b0, 8'h00, 2'b10, 10'h154, 0, "post_rst_idle");
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tmds_encoder.md
TMDS_ENCODER -- requirements
Module: tmds_encoder

Interface
REQ-001 SHALL have parameter CNTW, default 5, signed running-disparity counter width in bits; minimum 5.
REQ-002 SHALL have port clk_pix  input  1  pixel clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_pix  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have port de  input  1  data enable; 1 = video data, 0 = control period.
REQ-005 SHALL have port din  input  8  colour channel byte.
REQ-006 SHALL have port ctrl  input  2  control bits (ch0: {vsync,hsync}; ch1/ch2: 2'b00).
REQ-007 SHALL have port tmds  output  10  registered TMDS symbol; bit 0 is transmitted first.

Function
REQ-008 SHALL count ones in din as N1d and select XNOR when N1d>4 or (N1d==4 and din[0]==0), otherwise XOR.
REQ-009 SHALL form q_m: q_m[0]=din[0]; q_m[i]=q_m[i-1] XOR/XNOR din[i] for i=1..7; q_m[8]=1 for XOR, 0 for XNOR.
REQ-010 SHALL compute N1q and N0q as the ones and zeros counts of q_m[7:0], and hold running disparity cnt as a signed CNTW-bit register.
REQ-011 Branch A, when cnt==0 or N1q==N0q: tmds={~q_m[8], q_m[8], q_m[8]?q_m[7:0]:~q_m[7:0]}; cnt += q_m[8]?(N1q-N0q):(N0q-N1q).
REQ-012 Branch B, when (cnt>0 and N1q>N0q) or (cnt<0 and N0q>N1q): tmds={1, q_m[8], ~q_m[7:0]}; cnt += 2*q_m[8] + (N0q-N1q).
REQ-013 Branch C, otherwise: tmds={0, q_m[8], q_m[7:0]}; cnt += (N1q-N0q) - 2*(~q_m[8]).
REQ-014 SHALL perform all disparity arithmetic signed at CNTW bits; |cnt| never exceeds 10, so no saturation.
REQ-015 When de=0, tmds SHALL be 0x354 for ctrl=00, 0x0AB for ctrl=01, 0x154 for ctrl=10, 0x2AB for ctrl=11, and cnt SHALL load 0.
REQ-016 A de 0->1 transition SHALL start encoding from cnt=0 with no idle or bubble cycle.
REQ-017 Latency from de/din/ctrl to tmds SHALL be 1 cycle (see REQ-020); the block accepts one input every cycle.
REQ-018 de, din and ctrl SHALL travel together through every pipeline stage so each symbol matches its own inputs.

Reset
REQ-019 While rst_pix is high: tmds=0x354, cnt=0, and every pipeline de/ctrl register =0, taking effect immediately (asynchronous); release mid-frame resumes with the next input.

Configuration
REQ-020 With TMDS_PIPE_EN defined, SHALL register q_m, q_m-derived counts, de and ctrl after the XOR/XNOR stage, giving 2-cycle latency; without it, latency is 1 cycle, and the symbol sequences in both builds SHALL be identical apart from that delay.

Structure
REQ-021 Package isle_tmds_pkg SHALL hold the four control-code constants and the symbol width (10).
REQ-022 Sub-module tmds_qm_stage SHALL implement REQ-008..REQ-009 combinationally, outputting q_m[8:0].
REQ-023 tmds_encoder SHALL own the disparity register, the branch select and the optional pipeline register.

Verification
REQ-024 Reset held, then de=0 and ctrl=00 -> tmds=0x354 during reset and after release.
REQ-025 de=0, ctrl stepped 01, 10, 11 -> tmds 0x0AB, 0x154, 0x2AB after the configured latency.
REQ-026 de=1, din=0x00 for three cycles from cnt=0 -> tmds 0x100, 0x3FF, 0x100; cnt -8, +2, -6.
REQ-027 de=1, din=0xFF from cnt=0 -> tmds=0x200, cnt=-8.
REQ-028 10,000 random din with de=1, checked against a behavioural model -> exact symbol match, |cnt|<=10, and a de=0 cycle returns cnt to 0.
REQ-029 rst_pix asserted mid-line for 1 cycle -> tmds=0x354 asynchronously; the next data symbol is encoded from cnt=0; test run both with and without TMDS_PIPE_EN.
